// File: rtl/spi_pkg.sv
// Shared definitions for both ends of the mode-3 SPI link (master and slave blocks).
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} spi_state_t;

    localparam int   SPI_DATA_W = 16;
    localparam logic SPI_CPOL   = 1'b1;  // SCK idle level
    localparam logic SPI_CPHA   = 1'b1;  // shift on leading (falling) edge, sample on trailing (rising)

endpackage

// File: rtl/spi_clk_div.sv
// SCK generator: CLK_DIV-cycle phases, first edge is a fall on the cycle after en rises.
// Strobes are combinational and flag the edge the registered sck takes at the next clk edge.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic sck_fall,
    output logic sck_rise,
    output logic hi_end
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          active;
    logic          ph_end;

    assign ph_end   = active && (cnt == CW'(CLK_DIV - 1));
    assign hi_end   = ph_end && (sck == SPI_CPOL);
    assign sck_rise = ph_end && (sck != SPI_CPOL);
    assign sck_fall = en && (!active || hi_end);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt    <= '0;
            active <= 1'b0;
            sck    <= SPI_CPOL;
        end else begin
            active <= 1'b1;
            if (!active) begin
                sck <= ~SPI_CPOL;
                cnt <= '0;
            end else if (ph_end) begin
                sck <= ~sck;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// Mode-3 SPI master: one DATA_W full-duplex frame per handshake, rx_valid as cs_n rises.
// Accepts a word only in IDLE (tx_ready); no queueing, tx_valid elsewhere is ignored.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int TMR_W = 16;
    localparam int BC_W  = $clog2(DATA_W + 1);

    spi_state_t        state, state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-2:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              div_en;
    logic              sck_fall, sck_rise, hi_end;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .en       (div_en),
        .sck      (spi_sck),
        .sck_fall (sck_fall),
        .sck_rise (sck_rise),
        .hi_end   (hi_end)
    );

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // div_en covers the SETUP->XFER edge so the first sck fall lands on the first XFER cycle
    always_comb begin
        state_nxt = state;
        div_en    = 1'b0;
        case (state)
            IDLE:  if (tx_valid) state_nxt = SETUP;
            SETUP: if (tmr == TMR_W'(CS_SETUP - 1)) begin
                       state_nxt = XFER;
                       div_en    = 1'b1;
                   end
            XFER:  if (hi_end && bit_cnt == BC_W'(DATA_W)) state_nxt = HOLD;
                   else                                   div_en    = 1'b1;
            HOLD:  if (tmr == TMR_W'(CS_HOLD - 1)) state_nxt = GAP;
            GAP:   if (tmr == TMR_W'(CS_IDLE - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tmr      <= (state == IDLE || state_nxt != state) ? '0 : tmr + 1'b1;
            case (state)
                IDLE: if (tx_valid) begin
                    tx_sh    <= tx_data[DATA_W-2:0];
                    spi_mosi <= tx_data[DATA_W-1];
                    spi_cs_n <= 1'b0;
                    bit_cnt  <= '0;
                end
                XFER: begin
                    // bit 0 was presented during SETUP; later falls advance the shifter
                    if (sck_fall && bit_cnt != '0) begin
                        spi_mosi <= tx_sh[DATA_W-2];
                        tx_sh    <= tx_sh << 1;
                    end
                    if (sck_rise) begin
                        rx_sh   <= {rx_sh[DATA_W-2:0], spi_miso};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                HOLD: if (state_nxt == GAP) begin
                    rx_data  <= rx_sh;
                    rx_valid <= 1'b1;
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
